// File: rtl/memory_arbiter.sv
// Memory arbiter: shares one single-ported RAM between an icache and a dcache,
// one transaction at a time, with dcache priority bounded by a fairness counter.
module memory_arbiter #(
    parameter int TIMEOUT    = 255,
    parameter int FAIR_LIMIT = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic        ramrdy,
    output logic        err
);
    localparam int FW = $clog2(FAIR_LIMIT + 1);
    localparam int BW = $clog2(TIMEOUT + 1);
    localparam logic [FW-1:0] FAIR_MAX     = FW'(FAIR_LIMIT);
    localparam logic [BW-1:0] TIMEOUT_LAST = BW'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, IBUSY, DBUSY, IRESP, DRESP} state_t;

    state_t        state;
    logic [FW-1:0] fairCnt;
    logic [BW-1:0] busyCnt;
    logic          dReq;
    logic          grantI;

    assign dReq   = dREN | dWEN;
    assign grantI = iREN && (!dReq || fairCnt == FAIR_MAX);

    // ramaddr/ramstore double as the latched request registers; the strobes
    // are set on BUSY entry and cleared on the way out, so they are high
    // exactly while a BUSY state is held.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            fairCnt  <= '0;
            busyCnt  <= '0;
            iwait    <= 1'b1;
            dwait    <= 1'b1;
            iload    <= '0;
            dload    <= '0;
            ramREN   <= 1'b0;
            ramWEN   <= 1'b0;
            ramaddr  <= '0;
            ramstore <= '0;
            err      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grantI) begin
                        state    <= IBUSY;
                        ramaddr  <= iaddr;
                        ramstore <= '0;
                        ramREN   <= 1'b1;
                        busyCnt  <= '0;
                        fairCnt  <= '0;
                    end else if (dReq) begin
                        state    <= DBUSY;
                        ramaddr  <= daddr;
                        ramstore <= dstore;
                        ramREN   <= ~dWEN;
                        ramWEN   <= dWEN;
                        busyCnt  <= '0;
                        if (!iREN)
                            fairCnt <= '0;
                        else if (fairCnt != FAIR_MAX)
                            fairCnt <= fairCnt + 1'b1;
                    end
                end
                IBUSY, DBUSY: begin
                    // A timeout completes the transaction like a ramrdy, but
                    // with zero data and the sticky error flag raised.
                    if (ramrdy || busyCnt == TIMEOUT_LAST) begin
                        ramREN <= 1'b0;
                        ramWEN <= 1'b0;
                        if (!ramrdy)
                            err <= 1'b1;
                        if (state == IBUSY) begin
                            iload <= ramrdy ? ramload : '0;
                            iwait <= 1'b0;
                            state <= IRESP;
                        end else begin
                            if (!ramrdy)
                                dload <= '0;
                            else if (!ramWEN)
                                dload <= ramload;
                            dwait <= 1'b0;
                            state <= DRESP;
                        end
                    end else begin
                        busyCnt <= busyCnt + 1'b1;
                    end
                end
                IRESP: begin
                    iwait <= 1'b1;
                    state <= IDLE;
                end
                DRESP: begin
                    dwait <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_memory_arbiter.sv
// Testbench for memory_arbiter: a behavioural RAM answers strobes after a
// programmable delay while a scoreboard of expected responses is checked in order.
module tb_memory_arbiter;
    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        iREN = 1'b0;
    logic [31:0] iaddr = '0;
    logic        iwait;
    logic [31:0] iload;
    logic        dREN = 1'b0;
    logic        dWEN = 1'b0;
    logic [31:0] daddr = '0;
    logic [31:0] dstore = '0;
    logic        dwait;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload = '0;
    logic        ramrdy = 1'b0;
    logic        err;

    typedef struct packed {
        logic        isI;
        logic        chk;
        logic [31:0] data;
    } resp_t;

    resp_t       expq[$];
    logic [63:0] writeLog[$];
    int          checks = 0;
    int          errors = 0;
    int          ramDelay = 0;
    bit          ramEnable = 1'b1;
    int          busyK = 0;
    logic        bothStrobes = 1'b0;
    logic        wValid = 1'b0;
    logic [31:0] wAddr = '0;
    logic [31:0] wData = '0;

    memory_arbiter #(.TIMEOUT(255), .FAIR_LIMIT(4)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramrdy(ramrdy), .err(err)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] ramInit(input logic [31:0] a);
        return (a == 32'h40) ? 32'h8C22_0004 : {a[15:0] ^ 16'h5A5A, a[15:0]};
    endfunction

    // RAM model: pulses ramrdy in BUSY cycle number ramDelay (0 = first cycle).
    always @(negedge CLK) begin
        if (ramREN || ramWEN) begin
            if (ramREN && ramWEN)
                bothStrobes <= 1'b1;
            if (ramEnable && busyK == ramDelay) begin
                ramrdy <= 1'b1;
                if (ramWEN) begin
                    wValid <= 1'b1;
                    wAddr  <= ramaddr;
                    wData  <= ramstore;
                    writeLog.push_back({ramaddr, ramstore});
                    ramload <= 32'h0BAD_F00D;
                end else begin
                    ramload <= (wValid && wAddr == ramaddr) ? wData : ramInit(ramaddr);
                end
            end else begin
                ramrdy <= 1'b0;
            end
            busyK <= busyK + 1;
        end else begin
            ramrdy <= 1'b0;
            busyK  <= 0;
        end
    end

    task automatic doReset();
        RST  = 1'b1;
        iREN = 1'b0;
        dREN = 1'b0;
        dWEN = 1'b0;
        repeat (3) @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        checks++;
        if ({iwait, dwait, ramREN, ramWEN, err} !== 5'b11000) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: got iwait,dwait,ramREN,ramWEN,err=%b required 11000",
                     {iwait, dwait, ramREN, ramWEN, err});
        end
        checks++;
        if ({ramaddr, ramstore, iload, dload} !== 128'h0) begin
            errors++;
            $display("[TB] FAIL reset_data: got ramaddr=%h ramstore=%h iload=%h dload=%h required all 0",
                     ramaddr, ramstore, iload, dload);
        end
        RST = 1'b0;
    endtask

    task automatic test_iread();
        resp_t e;
        int n = 0, rd = 0, lat = -1, got = 0;
        ramDelay = 0;
        @(negedge CLK);
        iREN  = 1'b1;
        iaddr = 32'h40;
        expq.push_back('{1'b1, 1'b1, 32'h8C22_0004});
        while (got < 1 && n < 20) begin
            @(negedge CLK);
            n++;
            if (ramREN) rd++;
            if (!iwait || !dwait) begin
                got++;
                lat = n;
                iREN = 1'b0;
                checks++;
                e = expq.pop_front();
                if ({!iwait, !dwait} !== {e.isI, !e.isI} || iload !== e.data) begin
                    errors++;
                    $display("[TB] FAIL iread_resp: got iwait=%b dwait=%b iload=%h required iwait=0 iload=%h",
                             iwait, dwait, iload, e.data);
                end
            end
        end
        checks++;
        if (lat != 2) begin
            errors++;
            $display("[TB] FAIL iread_latency: got %0d cycles required 2", lat);
        end
        checks++;
        if (rd != 1) begin
            errors++;
            $display("[TB] FAIL iread_strobe: ramREN high %0d cycles required 1", rd);
        end
    endtask

    task automatic test_write_priority();
        resp_t e;
        logic [31:0] gotData;
        logic        seen = 1'b0, firstW = 1'b0;
        logic [31:0] firstA = '0;
        int n = 0, got = 0;
        ramDelay = 1;
        @(negedge CLK);
        iREN   = 1'b1;
        iaddr  = 32'h44;
        dWEN   = 1'b1;
        daddr  = 32'h100;
        dstore = 32'hDEAD_BEEF;
        expq.push_back('{1'b0, 1'b0, 32'h0});
        expq.push_back('{1'b1, 1'b1, ramInit(32'h44)});
        while (got < 3 && n < 60) begin
            @(negedge CLK);
            n++;
            if (!seen && (ramREN || ramWEN)) begin
                seen   = 1'b1;
                firstW = ramWEN;
                firstA = ramaddr;
            end
            if (!iwait || !dwait) begin
                got++;
                gotData = !iwait ? iload : dload;
                checks++;
                if (expq.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL wr_resp: unexpected response iwait=%b dwait=%b", iwait, dwait);
                end else begin
                    e = expq.pop_front();
                    if ({!iwait, !dwait} !== {e.isI, !e.isI} || (e.chk && gotData !== e.data)) begin
                        errors++;
                        $display("[TB] FAIL wr_resp: got icache=%b dcache=%b data=%h required icache=%b data=%h",
                                 !iwait, !dwait, gotData, e.isI, e.data);
                    end
                end
                if (!dwait) begin
                    dWEN = 1'b0;
                    dREN = 1'b0;
                end
                if (!iwait) begin
                    iREN = 1'b0;
                    // Read back the written word through the dcache port.
                    dREN  = 1'b1;
                    daddr = 32'h100;
                    expq.push_back('{1'b0, 1'b1, 32'hDEAD_BEEF});
                end
            end
        end
        checks++;
        if (got != 3) begin
            errors++;
            $display("[TB] FAIL wr_count: got %0d responses required 3", got);
        end
        checks++;
        if ({firstW, firstA} !== {1'b1, 32'h100}) begin
            errors++;
            $display("[TB] FAIL wr_first: got ramWEN=%b ramaddr=%h required ramWEN=1 ramaddr=00000100",
                     firstW, firstA);
        end
        checks++;
        if (writeLog.size() != 1 || writeLog[0] !== {32'h100, 32'hDEAD_BEEF}) begin
            errors++;
            $display("[TB] FAIL wr_bus: got %0d writes first=%h required 1 write 00000100deadbeef",
                     writeLog.size(), (writeLog.size() > 0) ? writeLog[0] : 64'h0);
        end
    endtask

    task automatic test_fairness();
        resp_t e;
        logic [31:0] gotData;
        int n = 0, got = 0;
        doReset();
        ramDelay = 0;
        for (int k = 0; k < 10; k++) begin
            if (k % 5 == 4) expq.push_back('{1'b1, 1'b1, ramInit(32'h200)});
            else            expq.push_back('{1'b0, 1'b1, ramInit(32'h300)});
        end
        iREN  = 1'b1;
        iaddr = 32'h200;
        dREN  = 1'b1;
        daddr = 32'h300;
        while (got < 10 && n < 200) begin
            @(negedge CLK);
            n++;
            if (!iwait || !dwait) begin
                got++;
                gotData = !iwait ? iload : dload;
                checks++;
                e = expq.pop_front();
                if ({!iwait, !dwait} !== {e.isI, !e.isI} || gotData !== e.data) begin
                    errors++;
                    $display("[TB] FAIL fair_grant%0d: got icache=%b dcache=%b data=%h required icache=%b data=%h",
                             got, !iwait, !dwait, gotData, e.isI, e.data);
                end
                if (got == 10) begin
                    iREN = 1'b0;
                    dREN = 1'b0;
                end
            end
        end
        checks++;
        if (got != 10) begin
            errors++;
            $display("[TB] FAIL fair_count: got %0d responses required 10", got);
        end
    endtask

    task automatic test_drop();
        resp_t e;
        int n = 0, lat = -1;
        ramDelay = 3;
        @(negedge CLK);
        iREN  = 1'b1;
        iaddr = 32'h80;
        expq.push_back('{1'b1, 1'b1, ramInit(32'h80)});
        while (lat < 0 && n < 30) begin
            @(negedge CLK);
            n++;
            if (ramREN) iREN = 1'b0;
            if (!iwait || !dwait) begin
                lat = n;
                checks++;
                e = expq.pop_front();
                if (iwait !== 1'b0 || dwait !== 1'b1 || iload !== e.data) begin
                    errors++;
                    $display("[TB] FAIL drop_resp: got iwait=%b dwait=%b iload=%h required iwait=0 iload=%h",
                             iwait, dwait, iload, e.data);
                end
            end
        end
        checks++;
        if (lat != 5) begin
            errors++;
            $display("[TB] FAIL drop_latency: got %0d cycles required 5", lat);
        end
    endtask

    task automatic test_timeout();
        resp_t e;
        logic [31:0] gotData;
        int n = 0, busy = 0, got = 0;
        logic errAtResp = 1'b0;
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL to_err_before: got err=%b required 0", err);
        end
        ramEnable = 1'b0;
        @(negedge CLK);
        dREN  = 1'b1;
        daddr = 32'h500;
        expq.push_back('{1'b0, 1'b1, 32'h0});
        while (got < 2 && n < 400) begin
            @(negedge CLK);
            n++;
            if (ramREN && got == 0) busy++;
            if (!iwait || !dwait) begin
                got++;
                gotData = !iwait ? iload : dload;
                checks++;
                e = expq.pop_front();
                if ({!iwait, !dwait} !== {e.isI, !e.isI} || gotData !== e.data) begin
                    errors++;
                    $display("[TB] FAIL to_resp%0d: got icache=%b dcache=%b data=%h required icache=%b data=%h",
                             got, !iwait, !dwait, gotData, e.isI, e.data);
                end
                if (got == 1) begin
                    errAtResp = err;
                    ramEnable = 1'b1;
                    ramDelay  = 0;
                    daddr     = 32'h504;
                    expq.push_back('{1'b0, 1'b1, ramInit(32'h504)});
                end else begin
                    dREN = 1'b0;
                end
            end
        end
        checks++;
        if (busy != 255 || got != 2) begin
            errors++;
            $display("[TB] FAIL to_cycles: got %0d busy cycles %0d responses required 255 and 2", busy, got);
        end
        checks++;
        if (errAtResp !== 1'b1 || err !== 1'b1) begin
            errors++;
            $display("[TB] FAIL to_err_sticky: got err=%b at timeout, err=%b after, required 1 and 1",
                     errAtResp, err);
        end
    endtask

    task automatic test_reset_mid();
        resp_t e;
        int n = 0, lat = -1, stray = 0;
        doReset();
        ramDelay = 5;
        dREN  = 1'b1;
        daddr = 32'h600;
        while (!ramREN && n < 10) begin
            @(negedge CLK);
            n++;
        end
        @(negedge CLK);
        RST  = 1'b1;
        dREN = 1'b0;
        @(negedge CLK);
        checks++;
        if ({iwait, dwait, ramREN, ramWEN, err} !== 5'b11000 || {ramaddr, ramstore, iload, dload} !== 128'h0) begin
            errors++;
            $display("[TB] FAIL rstmid_out: got iwait,dwait,ramREN,ramWEN,err=%b ramaddr=%h ramstore=%h iload=%h dload=%h required 11000 and zeros",
                     {iwait, dwait, ramREN, ramWEN, err}, ramaddr, ramstore, iload, dload);
        end
        RST = 1'b0;
        repeat (8) begin
            @(negedge CLK);
            if (!iwait || !dwait || ramREN || ramWEN) stray++;
        end
        checks++;
        if (stray != 0) begin
            errors++;
            $display("[TB] FAIL rstmid_quiet: got %0d active cycles after reset required 0", stray);
        end
        ramDelay = 0;
        dREN  = 1'b1;
        daddr = 32'h604;
        expq.push_back('{1'b0, 1'b1, ramInit(32'h604)});
        n = 0;
        while (lat < 0 && n < 20) begin
            @(negedge CLK);
            n++;
            if (!iwait || !dwait) begin
                lat = n;
                dREN = 1'b0;
                checks++;
                e = expq.pop_front();
                if (dwait !== 1'b0 || iwait !== 1'b1 || dload !== e.data) begin
                    errors++;
                    $display("[TB] FAIL rstmid_resp: got iwait=%b dwait=%b dload=%h required dwait=0 dload=%h",
                             iwait, dwait, dload, e.data);
                end
            end
        end
        checks++;
        if (lat != 2) begin
            errors++;
            $display("[TB] FAIL rstmid_latency: got %0d cycles required 2", lat);
        end
    endtask

    initial begin
        test_reset();
        test_iread();
        test_write_priority();
        test_fairness();
        test_drop();
        test_timeout();
        test_reset_mid();
        repeat (3) @(negedge CLK);
        checks++;
        if (expq.size() != 0 || bothStrobes !== 1'b0) begin
            errors++;
            $display("[TB] FAIL final: got %0d pending responses, both strobes seen=%b required 0 and 0",
                     expq.size(), bothStrobes);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255: max cycles a BUSY state waits for ramrdy before aborting.
REQ-002 Parameter FAIR_LIMIT, default 4: consecutive dcache grants allowed while icache waits.
REQ-003 CLK  in  1  sole clock, all state updates on rising edge.
REQ-004 RST  in  1  reset, synchronous, active-high.
REQ-005 iREN  in  1  icache read request, held until iwait low.
REQ-006 iaddr  in  32  icache word address.
REQ-007 iwait  out  1  low exactly in icache response cycle, else high.
REQ-008 iload  out  32  icache read data, valid when iwait low.
REQ-009 dREN  in  1  dcache read request.
REQ-010 dWEN  in  1  dcache write request.
REQ-011 daddr  in  32  dcache word address.
REQ-012 dstore  in  32  dcache write data.
REQ-013 dwait  out  1  low exactly in dcache response cycle, else high.
REQ-014 dload  out  32  dcache read data, valid when dwait low.
REQ-015 ramREN  out  1  RAM read strobe.
REQ-016 ramWEN  out  1  RAM write strobe.
REQ-017 ramaddr  out  32  RAM address.
REQ-018 ramstore  out  32  RAM write data.
REQ-019 ramload  in  32  RAM read data, valid with ramrdy.
REQ-020 ramrdy  in  1  RAM completion, single-cycle pulse.
REQ-021 err  out  1  sticky RAM-timeout flag.

Function
REQ-022 FSM states IDLE, IBUSY, DBUSY, IRESP, DRESP; one transaction in flight at a time.
REQ-023 IDLE: no request -> stay; else grant per REQ-024/025, latch address/data/op into registers, go IBUSY or DBUSY.
REQ-024 Both requesting: dcache wins unless fairness counter == FAIR_LIMIT, then icache wins.
REQ-025 Fairness counter (width ceil(log2(FAIR_LIMIT+1))): +1 on dcache grant with iREN high; cleared on icache grant or dcache grant with iREN low; saturates at FAIR_LIMIT.
REQ-026 dREN and dWEN both high: treated as write; ramREN stays low.
REQ-027 xBUSY: ramaddr/ramstore driven from latched registers; ramREN (read) or ramWEN (write) held high every cycle; strobes low in all other states.
REQ-028 xBUSY with ramrdy high: capture ramload into owner's load register (reads only), go xRESP.
REQ-029 xRESP: owner's wait low for exactly one cycle, then IDLE; new grant not before the following cycle.
REQ-030 Latency: request high in IDLE cycle t, ramrdy in cycle t+1 -> wait low in cycle t+2; each extra RAM cycle adds one.
REQ-031 Busy counter cleared on BUSY entry, +1 per BUSY cycle without ramrdy; at TIMEOUT -> set err, owner load register = 0, go xRESP.
REQ-032 err stays high until RST; arbitration continues normally after it.
REQ-033 Requester dropping its request mid-transaction: RAM access still completes; response cycle still occurs; no state corrupted.
REQ-034 iload/dload hold last captured value between responses; non-owner wait stays high throughout.
REQ-035 ramrdy outside BUSY states ignored.

Reset
REQ-036 RST high at any edge, including mid-transaction -> IDLE, iwait=dwait=1, ramREN=ramWEN=0, ramaddr=ramstore=0, iload=dload=0, err=0, both counters 0.
REQ-037 In-flight transaction aborted without response; first grant possible in cycle after RST falls.

Verification
REQ-038 iREN, iaddr=0x40, ramrdy one cycle after BUSY entry, ramload=0x8C220004 -> iwait low 2 cycles after request, iload=0x8C220004, ramREN seen 1 cycle.
REQ-039 iREN and dWEN together, daddr=0x100, dstore=0xDEADBEEF -> write served first (ramWEN, ramaddr=0x100), then icache read; ramREN never high during write.
REQ-040 Both requesting continuously, ramrdy immediate -> grants D,D,D,D,I repeating (FAIR_LIMIT=4).
REQ-041 dREN, ramrdy never asserted -> after 255 BUSY cycles err=1, dwait low one cycle with dload=0, next request served normally, err stays 1.
REQ-042 RST asserted during DBUSY -> next cycle all outputs at reset values, no dwait-low cycle, later request completes with nominal latency.
